// File: rtl/cle_key_pkg.sv
// Shared types and constants for the CLE key initiator: FSM states, bus phase count, address map.
package cle_key_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_STRB_LO = 3'd2,
    S_STRB_HI = 3'd3,
    S_HOLD    = 3'd4,
    S_DONE    = 3'd5
  } cle_state_e;

  localparam int unsigned PHASES    = 4;
  localparam logic [1:0]  BA_REGION = 2'b01;

  // Target register address: region in [13:12], payload nibble in [7:4], everything else zero.
  function automatic logic [13:0] ba_word(input logic [3:0] nib);
    return {BA_REGION, 4'h0, nib, 4'h0};
  endfunction

endpackage

// File: rtl/cle_key_initiator_if.sv
// Target-side bus of the CLE key initiator: address, qualifier, select, strobe clock and serial return.
interface cle_key_initiator_if;
  logic [13:0] ba;
  logic        br_w;
  logic        sser;
  logic        bclk;
  logic        sdrd;

  modport master (output ba, output br_w, output sser, output bclk, input sdrd);
  modport slave  (input ba, input br_w, input sser, input bclk, output sdrd);
endinterface

// File: rtl/cle_bus_phaser.sv
// Sequences each bus cycle through ADDR/STRB_LO/STRB_HI/HOLD and reports cycle completion.
module cle_bus_phaser
  import cle_key_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_go,
  input  logic       i_last,
  output cle_state_e o_state,
  output logic       o_cyc_end,
  output logic       o_sser,
  output logic       o_bclk,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned PH_W = (PHASES > 1) ? $clog2(PHASES) : 1;

  logic            r_act;
  logic            r_done;
  logic [PH_W-1:0] r_ph;
  logic            w_cyc_end;

  assign w_cyc_end = r_act && (r_ph == PH_W'(PHASES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act  <= 1'b0;
      r_done <= 1'b0;
      r_ph   <= '0;
    end else begin
      r_done <= w_cyc_end && i_last;
      if (!r_act) begin
        if (i_go) begin
          r_act <= 1'b1;
          r_ph  <= '0;
        end
      end else if (w_cyc_end) begin
        r_ph <= '0;
        if (i_last) begin
          r_act <= 1'b0;
        end
      end else begin
        r_ph <= r_ph + PH_W'(1);
      end
    end
  end

  always_comb begin
    o_state = S_IDLE;
    if (r_done) begin
      o_state = S_DONE;
    end else if (r_act) begin
      case (r_ph)
        PH_W'(0): o_state = S_ADDR;
        PH_W'(1): o_state = S_STRB_LO;
        PH_W'(2): o_state = S_STRB_HI;
        default:  o_state = S_HOLD;
      endcase
    end
  end

  // Target is selected only across the strobe pair; bclk rises mid-select.
  assign o_sser    = !((o_state == S_STRB_LO) || (o_state == S_STRB_HI));
  assign o_bclk    = (o_state == S_STRB_HI);
  assign o_cyc_end = w_cyc_end;
  assign o_busy    = r_act;
  assign o_done    = r_done;

endmodule

// File: rtl/cle_key_initiator.sv
// Sends KEY_LEN unlock bus cycles carrying key nibbles, then reads NBITS serial bits MSB-first.
module cle_key_initiator
  import cle_key_pkg::*;
#(
  parameter int unsigned KEY_LEN = 4,
  parameter int unsigned NBITS   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*KEY_LEN-1:0]   key,
  output logic                   busy,
  output logic                   done,
  output logic [NBITS-1:0]       rdata,
  cle_key_initiator_if.master    bus
);

  localparam int unsigned NCYC = KEY_LEN + NBITS;
  localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  logic [4*KEY_LEN-1:0] r_key;
  logic [CW-1:0]        r_cyc;
  logic [NBITS-1:0]     r_rdata;

  cle_state_e w_state;
  logic       w_accept;
  logic       w_last;
  logic       w_read;
  logic       w_cyc_end;
  logic       w_sser;
  logic       w_bclk;
  logic       w_busy;
  logic       w_done;

  cle_bus_phaser u_phaser (
    .clk       (clk),
    .rst       (rst),
    .i_go      (w_accept),
    .i_last    (w_last),
    .o_state   (w_state),
    .o_cyc_end (w_cyc_end),
    .o_sser    (w_sser),
    .o_bclk    (w_bclk),
    .o_busy    (w_busy),
    .o_done    (w_done)
  );

  assign w_accept = start && (w_state == S_IDLE);
  assign w_last   = (r_cyc == CW'(NCYC - 1));
  assign w_read   = (r_cyc >= CW'(KEY_LEN));

  // r_key shifts down one nibble per cycle and fills with zeros, so read cycles carry 4'h0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key   <= '0;
      r_cyc   <= '0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_key   <= key;
      r_cyc   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_cyc_end) begin
        r_key <= r_key >> 4;
        if (!w_last) begin
          r_cyc <= r_cyc + CW'(1);
        end
      end
      if ((w_state == S_STRB_HI) && w_read) begin
        r_rdata <= (r_rdata << 1) | NBITS'(bus.sdrd);
      end
    end
  end

  always_comb begin
    bus.ba   = '0;
    bus.br_w = 1'b0;
    if (w_busy) begin
      bus.ba   = ba_word(r_key[3:0]);
      bus.br_w = 1'b1;
    end
  end

  assign bus.sser = w_sser;
  assign bus.bclk = w_bclk;
  assign busy     = w_busy;
  assign done     = w_done;
  assign rdata    = r_rdata;

endmodule

// File: tb/tb_cle_key_initiator.sv
// Randomised bench for cle_key_initiator: driver pushes expectations, a negedge monitor checks them.
module tb_cle_key_initiator;

  localparam int unsigned KL   = 4;
  localparam int unsigned NB   = 16;
  localparam int unsigned NCYC = KL + NB;
  localparam int          LAT  = 4 * NCYC + 1;

  logic            clk   = 1'b0;
  logic            rst   = 1'b1;
  logic            start = 1'b0;
  logic [4*KL-1:0] key   = '0;
  logic            busy;
  logic            done;
  logic [NB-1:0]   rdata;

  cle_key_initiator_if bus_if ();

  cle_key_initiator #(
    .KEY_LEN (KL),
    .NBITS   (NB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .key   (key),
    .busy  (busy),
    .done  (done),
    .rdata (rdata),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Behavioural target: shifts out tgt_word MSB-first on read-cycle bclk rises; noise while deselected.
  logic [NB-1:0] tgt_word  = '0;
  logic          tgt_bit   = 1'b0;
  logic          noise_bit = 1'b0;
  int            tgt_idx   = 0;

  assign bus_if.sdrd = bus_if.sser ? noise_bit : tgt_bit;

  initial forever begin
    @(posedge bus_if.bclk or posedge rst);
    if (rst) begin
      tgt_idx = 0;
    end else begin
      if (tgt_idx >= KL) tgt_bit = tgt_word[NB - 1 - (tgt_idx - KL)];
      else tgt_bit = 1'($urandom_range(0, 1));
      tgt_idx = (tgt_idx == NCYC - 1) ? 0 : tgt_idx + 1;
    end
  end

  initial forever begin
    @(negedge clk);
    noise_bit = 1'($urandom_range(0, 1));
  end

  // Scoreboard
  logic [NB-1:0] exp_data_q[$];
  int            exp_t0_q[$];
  logic [3:0]    exp_nib_q[$];

  logic          m_prev_bclk = 1'b0;
  int            m_rises     = 0;
  logic [NB-1:0] m_hold      = '0;

  initial forever begin
    logic [13:0]   exp_ba;
    logic [NB-1:0] exp_w;
    int            t0;
    @(negedge clk);
    if (rst) begin
      exp_data_q.delete();
      exp_t0_q.delete();
      exp_nib_q.delete();
      m_rises = 0;
      m_hold  = '0;
    end else begin
      if (bus_if.bclk) begin
        check("sser_low_while_bclk", 64'(bus_if.sser), 64'(0));
        if (!m_prev_bclk) begin
          m_rises++;
          if (exp_nib_q.size() == 0) begin
            check("unexpected_bus_cycle", 64'(1), 64'(0));
          end else begin
            exp_ba = 14'h1000 | (14'(exp_nib_q.pop_front()) << 4);
            check("ba_cycle", 64'(bus_if.ba), 64'(exp_ba));
          end
        end
      end
      if (busy) check("br_w_busy", 64'(bus_if.br_w), 64'(1));
      if (!busy && !done) begin
        check("idle_outputs", 64'({bus_if.ba, bus_if.sser, bus_if.bclk, bus_if.br_w}), 64'(17'h4));
        check("rdata_hold", 64'(rdata), 64'(m_hold));
      end
      if (done) begin
        if (exp_data_q.size() == 0) begin
          check("spurious_done", 64'(1), 64'(0));
        end else begin
          exp_w = exp_data_q.pop_front();
          t0    = exp_t0_q.pop_front();
          check("rdata", 64'(rdata), 64'(exp_w));
          check("latency", 64'(cyc - t0), 64'(LAT));
          check("bclk_rises", 64'(m_rises), 64'(NCYC));
          m_hold = exp_w;
        end
        m_rises = 0;
      end
    end
    m_prev_bclk = bus_if.bclk;
  end

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic push_nibbles(input logic [4*KL-1:0] k);
    for (int i = 0; i < KL; i++) exp_nib_q.push_back(4'((k >> (4 * i)) & 16'hF));
    for (int i = 0; i < NB; i++) exp_nib_q.push_back(4'h0);
  endtask

  task automatic run_txn(input logic [4*KL-1:0] k, input logic [NB-1:0] w, input int ignore_at,
                         input bit start_in_done);
    int n;
    tgt_word = w;
    key      = k;
    start    = 1'b1;
    push_nibbles(k);
    exp_data_q.push_back(w);
    exp_t0_q.push_back(cyc);
    wait_edge();
    start = 1'b0;
    key   = 16'($urandom);
    n     = 1;
    while (!done && n < LAT + 20) begin
      start = (n == ignore_at);
      wait_edge();
      n++;
    end
    start = 1'b0;
    if (!done) begin
      check("done_timeout", 64'(0), 64'(1));
      rst = 1'b1;
      wait_edge();
      wait_edge();
      rst = 1'b0;
    end else if (start_in_done) begin
      start = 1'b1;
      key   = 16'($urandom);
      wait_edge();
      start = 1'b0;
      check("start_in_done_ignored", 64'(busy), 64'(0));
    end
    repeat (4) wait_edge();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    wait_edge();
    wait_edge();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_ba", 64'(bus_if.ba), 64'(0));
    check("rst_sser", 64'(bus_if.sser), 64'(1));
    check("rst_bclk", 64'(bus_if.bclk), 64'(0));
    check("rst_br_w", 64'(bus_if.br_w), 64'(0));
    rst = 1'b0;
    wait_edge();

    run_txn(16'h4A5A, 16'hC3E1, -1, 1'b0);
    run_txn(16'h4A5A, 16'($urandom), 10, 1'b1);

    // Reset while the second unlock cycle is in STRB_HI
    key      = 16'h4A5A;
    tgt_word = 16'hC3E1;
    start    = 1'b1;
    push_nibbles(16'h4A5A);
    wait_edge();
    start = 1'b0;
    repeat (6) wait_edge();
    check("strb_hi_before_rst", 64'({bus_if.bclk, bus_if.sser}), 64'(2'b10));
    rst = 1'b1;
    wait_edge();
    check("midrst_sser", 64'(bus_if.sser), 64'(1));
    check("midrst_bclk", 64'(bus_if.bclk), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_rdata", 64'(rdata), 64'(0));
    rst = 1'b0;
    wait_edge();
    run_txn(16'h4A5A, 16'hC3E1, -1, 1'b0);

    // Simultaneous start and reset
    start = 1'b1;
    rst   = 1'b1;
    wait_edge();
    check("simul_busy", 64'(busy), 64'(0));
    check("simul_br_w", 64'(bus_if.br_w), 64'(0));
    start = 1'b0;
    rst   = 1'b0;
    wait_edge();
    check("simul_busy_after", 64'(busy), 64'(0));
    repeat (3) wait_edge();

    run_txn(16'($urandom), 16'hFFFF, -1, 1'b0);

    for (int t = 0; t < 12; t++) begin
      run_txn(16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 79)) : -1,
              1'($urandom_range(0, 1)));
    end

    repeat (5) wait_edge();
    check("queues_drained", 64'(exp_data_q.size() + exp_nib_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cle_key_initiator.md
CLE_KEY_INITIATOR -- requirements
Module: cle_key_initiator

Interface
REQ-001 SHALL have parameter KEY_LEN, default 4, number of unlock bus cycles before readout.
REQ-002 SHALL have parameter NBITS, default 16, number of serial bits read after unlock.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, one-cycle request to run a full unlock-plus-readout transaction.
REQ-006 SHALL have port key, input, 4*KEY_LEN, unlock nibbles; nibble 0 is key[3:0] and is sent first; sampled on accepted start.
REQ-007 SHALL have port busy, output, 1, high from the cycle after an accepted start through the last HOLD phase.
REQ-008 SHALL have port done, output, 1, one-cycle pulse when rdata is valid.
REQ-009 SHALL have port rdata, output, NBITS, received serial word; first bit received lands in the MSB.
REQ-010 SHALL have port ba, output, 14, target bus address.
REQ-011 SHALL have port br_w, output, 1, bus read/write qualifier; the target responds only while high.
REQ-012 SHALL have port sser, output, 1, active-low target select.
REQ-013 SHALL have port bclk, output, 1, target register clock; the target advances on its rising edge.
REQ-014 SHALL have port sdrd, input, 1, serial data from the target; valid only while sser=0.

Function
REQ-015 SHALL run FSM states IDLE, ADDR, STRB_LO, STRB_HI, HOLD, DONE.
REQ-016 SHALL treat each bus cycle as ADDR -> STRB_LO -> STRB_HI -> HOLD, exactly 4 clk.
REQ-017 ADDR and HOLD: sser=1, bclk=0. STRB_LO: sser=0, bclk=0. STRB_HI: sser=0, bclk=1.
REQ-018 SHALL hold ba constant across all four phases of a bus cycle, with ba[13]=0 and ba[12]=1.
REQ-019 Unlock cycle k (0..KEY_LEN-1) SHALL drive ba[7:4]=key nibble k; all other ba bits are 0.
REQ-020 Read cycles (NBITS of them) SHALL drive ba[7:4]=4'h0; all other ba bits are 0.
REQ-021 SHALL drive br_w=1 in all non-IDLE/DONE states and br_w=0 otherwise.
REQ-022 In IDLE, SHALL drive ba=0, sser=1, bclk=0, br_w=0.
REQ-023 In STRB_HI of each read cycle, SHALL sample sdrd and shift it into rdata from the LSB.
REQ-024 After the last HOLD, SHALL enter DONE for 1 cycle with done=1, then return to IDLE.
REQ-025 Total latency SHALL be accepted start -> done = 4*(KEY_LEN+NBITS)+1 cycles.
REQ-026 SHALL ignore start while busy=1 or while in DONE.
REQ-027 start in IDLE SHALL enter ADDR on the next cycle and clear the bit and cycle counters.
REQ-028 rdata SHALL hold its value from DONE until the next accepted start.
REQ-029 SHALL keep cycle counters at ceil(log2(KEY_LEN+NBITS)) bits, with no wrap inside a transaction.

Reset
REQ-030 On rst=1 at a clk edge, SHALL enter IDLE from any state, including mid-strobe.
REQ-031 On reset, outputs SHALL be busy=0, done=0, rdata=0, ba=0, sser=1, bclk=0, br_w=0.
REQ-032 rst SHALL take priority over a simultaneous start.

Structure
REQ-033 SHALL place the FSM state enum, phase count (4), and ba[13:12] region constant (2'b01) in package cle_key_pkg.
REQ-034 SHALL implement phase sequencing (REQ-016/017) in sub-module cle_bus_phaser, which outputs a cycle-complete strobe.

Verification
REQ-035 KEY_LEN=4, key=16'h4A5A, start -> ba[7:4] sequence A,5,A,4 on unlock cycles; then 16 read cycles with ba[7:4]=0; done at cycle 81.
REQ-036 Behavioural target model returns 16'hC3E1 -> rdata=16'hC3E1 on the done pulse; bclk rises 20 times with sser=0 each time.
REQ-037 Second start at cycle 10 of a transaction -> ignored; exactly one done pulse at cycle 81.
REQ-038 rst asserted at cycle 7 (STRB_HI) -> next cycle sser=1, bclk=0, busy=0, rdata=0; a new start runs the full 81 cycles.
REQ-039 Simultaneous start and rst -> remains in IDLE, busy=0.
REQ-040 sdrd held at 1 throughout -> rdata=16'hFFFF; sdrd toggles only outside STRB_HI -> sampled values unaffected.
